// File: rtl/my_ifft_x4.sv
// 4-point radix-2 inverse FFT: registered input block, two butterfly stages,
// optional divide-by-4, one-cycle completion pulse.
module my_ifft_x4 #(
  parameter int unsigned DATA_SIZE = 16,
  parameter int unsigned SCALE     = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid,
  input  logic [3:0][DATA_SIZE-1:0] data_in_i,
  input  logic [3:0][DATA_SIZE-1:0] data_in_q,
  output logic                      busy,
  output logic [3:0][DATA_SIZE-1:0] data_out_i,
  output logic [3:0][DATA_SIZE-1:0] data_out_q,
  output logic                      complete,
  output logic [2:0]                stateIFFT
);

  localparam int unsigned W = DATA_SIZE + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'b000,
    STAGE1 = 3'b001,
    STAGE2 = 3'b010,
    DONE   = 3'b111
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_busy;
  logic   r_complete;
  logic   w_load;
  logic   w_st1;
  logic   w_st2;

  logic [3:0][DATA_SIZE-1:0] r_in_i;
  logic [3:0][DATA_SIZE-1:0] r_in_q;
  logic [3:0][W-1:0]         r_a_i;
  logic [3:0][W-1:0]         r_a_q;
  logic [3:0][DATA_SIZE-1:0] r_out_i;
  logic [3:0][DATA_SIZE-1:0] r_out_q;
  logic [3:0][W-1:0]         w_a_i;
  logic [3:0][W-1:0]         w_a_q;
  logic [3:0][W-1:0]         w_x_i;
  logic [3:0][W-1:0]         w_x_q;
  logic [3:0][DATA_SIZE-1:0] w_y_i;
  logic [3:0][DATA_SIZE-1:0] w_y_q;

  function automatic logic [W-1:0] sx(input logic [DATA_SIZE-1:0] v);
    return {{2{v[DATA_SIZE-1]}}, v};
  endfunction

  // Wrap to DATA_SIZE bits, or arithmetic shift right by 2 when scaling.
  function automatic logic [DATA_SIZE-1:0] trim(input logic [W-1:0] v);
    if (SCALE != 0) return v[W-1:2];
    else            return v[DATA_SIZE-1:0];
  endfunction

  // State register; busy/complete registered alongside the state they decode.
  always_ff @(posedge clk or negedge reset_n) begin : p_state
    if (!reset_n) begin
      r_state    <= IDLE;
      r_busy     <= 1'b0;
      r_complete <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_busy     <= (w_next != IDLE);
      r_complete <= (w_next == DONE);
    end
  end

  always_comb begin : p_next
    w_next = r_state;
    case (r_state)
      IDLE:    if (valid) w_next = STAGE1;
      STAGE1:  w_next = STAGE2;
      STAGE2:  w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin : p_ctrl
    w_load = 1'b0;
    w_st1  = 1'b0;
    w_st2  = 1'b0;
    case (r_state)
      IDLE:    w_load = valid;
      STAGE1:  w_st1  = 1'b1;
      STAGE2:  w_st2  = 1'b1;
      default: ;
    endcase
  end

  // Stage 1 butterflies, then stage 2 with twiddle +j on the odd branch.
  always_comb begin : p_datapath
    w_a_i[0] = sx(r_in_i[0]) + sx(r_in_i[2]);
    w_a_i[1] = sx(r_in_i[0]) - sx(r_in_i[2]);
    w_a_i[2] = sx(r_in_i[1]) + sx(r_in_i[3]);
    w_a_i[3] = sx(r_in_i[1]) - sx(r_in_i[3]);
    w_a_q[0] = sx(r_in_q[0]) + sx(r_in_q[2]);
    w_a_q[1] = sx(r_in_q[0]) - sx(r_in_q[2]);
    w_a_q[2] = sx(r_in_q[1]) + sx(r_in_q[3]);
    w_a_q[3] = sx(r_in_q[1]) - sx(r_in_q[3]);

    w_x_i[0] = r_a_i[0] + r_a_i[2];
    w_x_q[0] = r_a_q[0] + r_a_q[2];
    w_x_i[2] = r_a_i[0] - r_a_i[2];
    w_x_q[2] = r_a_q[0] - r_a_q[2];
    w_x_i[1] = r_a_i[1] - r_a_q[3];
    w_x_q[1] = r_a_q[1] + r_a_i[3];
    w_x_i[3] = r_a_i[1] + r_a_q[3];
    w_x_q[3] = r_a_q[1] - r_a_i[3];

    for (int k = 0; k < 4; k++) begin
      w_y_i[k] = trim(w_x_i[k]);
      w_y_q[k] = trim(w_x_q[k]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin : p_data
    if (!reset_n) begin
      r_in_i  <= '0;
      r_in_q  <= '0;
      r_a_i   <= '0;
      r_a_q   <= '0;
      r_out_i <= '0;
      r_out_q <= '0;
    end else begin
      if (w_load) begin
        r_in_i <= data_in_i;
        r_in_q <= data_in_q;
      end
      if (w_st1) begin
        r_a_i <= w_a_i;
        r_a_q <= w_a_q;
      end
      if (w_st2) begin
        r_out_i <= w_y_i;
        r_out_q <= w_y_q;
      end
    end
  end

  assign busy       = r_busy;
  assign complete   = r_complete;
  assign data_out_i = r_out_i;
  assign data_out_q = r_out_q;
  assign stateIFFT  = r_state;

endmodule

// File: tb/tb_my_ifft_x4.sv
// Directed bench for my_ifft_x4: unscaled and scaled instances share stimulus.
module tb_my_ifft_x4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              valid;
  logic [3:0][15:0]  data_in_i;
  logic [3:0][15:0]  data_in_q;
  logic              busy0, busy1, complete0, complete1;
  logic [3:0][15:0]  out_i0, out_q0, out_i1, out_q1;
  logic [2:0]        state0, state1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  my_ifft_x4 #(.DATA_SIZE(16), .SCALE(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .valid(valid),
    .data_in_i(data_in_i), .data_in_q(data_in_q),
    .busy(busy0), .data_out_i(out_i0), .data_out_q(out_q0),
    .complete(complete0), .stateIFFT(state0)
  );

  my_ifft_x4 #(.DATA_SIZE(16), .SCALE(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .valid(valid),
    .data_in_i(data_in_i), .data_in_q(data_in_q),
    .busy(busy1), .data_out_i(out_i1), .data_out_q(out_q1),
    .complete(complete1), .stateIFFT(state1)
  );

  // Present one block for one edge (state must be IDLE), then count edges to complete.
  task automatic run_block(input logic [3:0][15:0] xi, input logic [3:0][15:0] xq,
                           output int lat);
    data_in_i = xi;
    data_in_q = xq;
    valid     = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    lat   = 1;
    while (complete0 !== 1'b1 && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (complete0 !== 1'b1) lat = 99;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    valid     = 1'b1;
    data_in_i = '0;
    data_in_q = '0;
    data_in_i[0] = 16'd1000;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({state0, busy0, complete0} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b required 00000", {state0, busy0, complete0});
    end
    n_checks++;
    if ({out_i0, out_q0, out_i1, out_q1} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h required 0", {out_i0, out_q0});
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    n_checks++;
    if (state0 !== 3'b001) begin
      n_fail++; $display("FAIL first_edge_accept: got %b required 001", state0);
    end
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (state0 !== 3'b000) begin
      n_fail++; $display("FAIL return_idle: got %b required 000", state0);
    end
  endtask

  task automatic test_idle_hold;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({state0, busy0} !== 4'b0000) begin
      n_fail++; $display("FAIL idle_hold: got %b required 0000", {state0, busy0});
    end
  endtask

  task automatic test_impulse;
    logic [3:0][15:0] xi, xq;
    int lat;
    xi = '0; xq = '0; xi[0] = 16'd1000;
    run_block(xi, xq, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL impulse_latency: got %0d required 3", lat);
    end
    n_checks++;
    if ({out_i0, out_q0} !== {{4{16'd1000}}, 64'h0}) begin
      n_fail++; $display("FAIL impulse_out: got %h required %h", {out_i0, out_q0}, {{4{16'd1000}}, 64'h0});
    end
    n_checks++;
    if ({out_i1, out_q1} !== {{4{16'd250}}, 64'h0}) begin
      n_fail++; $display("FAIL impulse_scaled: got %h required %h", {out_i1, out_q1}, {{4{16'd250}}, 64'h0});
    end
    @(posedge clk); #1;
    n_checks++;
    if (complete0 !== 1'b0) begin
      n_fail++; $display("FAIL complete_pulse_width: got %b required 0", complete0);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (out_i0 !== {4{16'd1000}}) begin
      n_fail++; $display("FAIL output_hold: got %h required %h", out_i0, {4{16'd1000}});
    end
  endtask

  task automatic test_single_bin;
    logic [3:0][15:0] xi, xq;
    int lat;
    xi = '0; xq = '0; xi[1] = 16'd1000;
    run_block(xi, xq, lat);
    n_checks++;
    if ({out_i0, out_q0} !== {16'h0000, 16'hFC18, 16'h0000, 16'd1000,
                              16'hFC18, 16'h0000, 16'd1000, 16'h0000}) begin
      n_fail++; $display("FAIL single_bin: got %h required 0000fc18000003e8fc18000003e80000", {out_i0, out_q0});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dc_scale;
    logic [3:0][15:0] xi, xq;
    int lat;
    xi = {4{16'd1000}}; xq = '0;
    run_block(xi, xq, lat);
    n_checks++;
    if ({out_i0, out_q0} !== {48'h0, 16'd4000, 64'h0}) begin
      n_fail++; $display("FAIL dc_unscaled: got %h required %h", {out_i0, out_q0}, {48'h0, 16'd4000, 64'h0});
    end
    n_checks++;
    if ({out_i1, out_q1} !== {48'h0, 16'd1000, 64'h0}) begin
      n_fail++; $display("FAIL dc_scaled: got %h required %h", {out_i1, out_q1}, {48'h0, 16'd1000, 64'h0});
    end
    @(posedge clk); #1;
    xi = '0; xi[0] = 16'hFFFD;
    run_block(xi, xq, lat);
    n_checks++;
    if (out_i1 !== {4{16'hFFFF}}) begin
      n_fail++; $display("FAIL scale_floor: got %h required %h", out_i1, {4{16'hFFFF}});
    end
    n_checks++;
    if (out_i0 !== {4{16'hFFFD}}) begin
      n_fail++; $display("FAIL negative_impulse: got %h required %h", out_i0, {4{16'hFFFD}});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_wrap;
    logic [3:0][15:0] xi, xq;
    int lat;
    xi = {4{16'h7FFF}}; xq = '0;
    run_block(xi, xq, lat);
    n_checks++;
    if (out_i0 !== {48'h0, 16'hFFFC}) begin
      n_fail++; $display("FAIL wrap_unscaled: got %h required %h", out_i0, {48'h0, 16'hFFFC});
    end
    n_checks++;
    if (out_i1 !== {48'h0, 16'h7FFF}) begin
      n_fail++; $display("FAIL wrap_scaled: got %h required %h", out_i1, {48'h0, 16'h7FFF});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_complex;
    logic [3:0][15:0] xi, xq;
    int lat;
    xi = {16'd7, 16'd5, 16'd3, 16'd1};
    xq = {16'd8, 16'd6, 16'd4, 16'd2};
    run_block(xi, xq, lat);
    n_checks++;
    if ({out_i0, out_q0} !== {16'hFFF8, 16'hFFFC, 16'h0000, 16'd16,
                              16'h0000, 16'hFFFC, 16'hFFF8, 16'd20}) begin
      n_fail++; $display("FAIL complex_unscaled: got %h required fff8fffc000000100000fffcfff80014", {out_i0, out_q0});
    end
    n_checks++;
    if ({out_i1, out_q1} !== {16'hFFFE, 16'hFFFF, 16'h0000, 16'd4,
                              16'h0000, 16'hFFFF, 16'hFFFE, 16'd5}) begin
      n_fail++; $display("FAIL complex_scaled: got %h required fffeffff000000040000fffffffe0005", {out_i1, out_q1});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [15:0] e;
    int busy_cnt;
    int done_cnt;
    busy_cnt = 0;
    done_cnt = 0;
    valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      data_in_i = '0;
      data_in_q = '0;
      data_in_i[0] = 16'(100 * (k + 1));
      @(posedge clk); #1;
      if (busy0) busy_cnt++;
      if (complete0) done_cnt++;
      if (k % 4 == 2) begin
        e = 16'(100 * (k - 1));
        n_checks++;
        if (complete0 !== 1'b1 || out_i0 !== {4{e}}) begin
          n_fail++; $display("FAIL b2b_block%0d: got complete=%b out=%h required 1 %h", k, complete0, out_i0, {4{e}});
        end
      end
    end
    valid = 1'b0;
    n_checks++;
    if (busy_cnt !== 9 || done_cnt !== 3) begin
      n_fail++; $display("FAIL b2b_counts: got busy=%0d done=%0d required 9 3", busy_cnt, done_cnt);
    end
  endtask

  task automatic test_reset_mid;
    logic [3:0][15:0] xi, xq;
    int lat;
    int seen;
    seen = 0;
    data_in_i = '0; data_in_q = '0; data_in_i[0] = 16'd500;
    valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (state0 !== 3'b010) begin
      n_fail++; $display("FAIL mid_state: got %b required 010", state0);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({out_i0, out_q0, out_i1, out_q1, state0, busy0, complete0} !== '0) begin
      n_fail++; $display("FAIL mid_reset_clear: got %h state=%b required 0", {out_i0, out_q0}, state0);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      if (complete0 || complete1) seen++;
    end
    n_checks++;
    if (seen !== 0 || out_i0 !== '0) begin
      n_fail++; $display("FAIL abort_no_complete: got pulses=%0d out=%h required 0 0", seen, out_i0);
    end
    xi = '0; xq = '0; xi[0] = 16'd1000;
    run_block(xi, xq, lat);
    n_checks++;
    if (lat !== 3 || out_i0 !== {4{16'd1000}}) begin
      n_fail++; $display("FAIL post_reset_impulse: got lat=%0d out=%h required 3 %h", lat, out_i0, {4{16'd1000}});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_hold();
    test_impulse();
    test_single_bin();
    test_dc_scale();
    test_wrap();
    test_complex();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
